// File: rtl/exe_pkg.sv
// Shared definitions for the exe_0x input-conditioning / logic blocks.
//   EXE_N_IN             - number of conditioned input channels
//   EXE_DEBOUNCE_DEFAULT - default debounce threshold in clock cycles
//   exe_in_vec_t         - one bit per channel (raw, clean and pulse vectors)
package exe_pkg;

    localparam int EXE_N_IN             = 3;
    localparam int EXE_DEBOUNCE_DEFAULT = 4;

    typedef logic [EXE_N_IN-1:0] exe_in_vec_t;

endpackage

// File: rtl/exe_debounce_channel.sv
// One input channel: synchroniser chain, debounce counter, clean level and
// registered edge pulses.
//   i_clk   - system clock, rising edge
//   i_rst   - synchronous active-high reset
//   i_raw   - asynchronous raw level
//   o_clean - debounced level
//   o_rise  - 1-cycle pulse on clean 0->1
//   o_fall  - 1-cycle pulse on clean 1->0
//   o_idle  - no pending change (counter at 0 and synchronised level == clean)
module exe_debounce_channel #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_idle
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_clean;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_q;

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            // plain FF chain, bit 0 samples the asynchronous input
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_sync_q == r_clean) begin
                // agreement (or glitch ended): restart the count from zero
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // threshold reached: accept level, pulse lands with it
                r_clean <= w_sync_q;
                r_cnt   <= '0;
                r_rise  <= w_sync_q;
                r_fall  <= ~w_sync_q;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clean = r_clean;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_idle  = (r_cnt == '0) && (w_sync_q == r_clean);

endmodule

// File: rtl/exe_05_input_conditioner.sv
// Synchronises and debounces N_IN raw switch/button inputs ahead of the
// exe_04 logic block; o_clean_out[i] drives downstream in(i+1).
//   i_clk        - system clock, rising edge
//   i_rst        - synchronous active-high reset
//   i_raw_in     - asynchronous raw inputs
//   o_clean_out  - debounced levels
//   o_rise_pulse - 1-cycle pulse per channel on clean 0->1
//   o_fall_pulse - 1-cycle pulse per channel on clean 1->0
//   o_stable     - high when no channel has a pending change
module exe_05_input_conditioner
    import exe_pkg::*;
#(
    parameter int N_IN            = EXE_N_IN,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = EXE_DEBOUNCE_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_IN-1:0] i_raw_in,
    output logic [N_IN-1:0] o_clean_out,
    output logic [N_IN-1:0] o_rise_pulse,
    output logic [N_IN-1:0] o_fall_pulse,
    output logic            o_stable
);

    logic [N_IN-1:0] w_idle;

    for (genvar g = 0; g < N_IN; g++) begin : g_ch
        exe_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (i_raw_in[g]),
            .o_clean (o_clean_out[g]),
            .o_rise  (o_rise_pulse[g]),
            .o_fall  (o_fall_pulse[g]),
            .o_idle  (w_idle[g])
        );
    end

    // purely from registered state, so no raw_in-to-output path
    assign o_stable = &w_idle;

endmodule

// File: tb/tb_exe_05_input_conditioner.sv
// Directed bench for exe_05_input_conditioner with default parameters
// (2 sync stages, 4-cycle debounce => accept on the 6th edge).
module tb_exe_05_input_conditioner;
    import exe_pkg::*;

    logic        clk;
    logic        rst;
    exe_in_vec_t raw;
    exe_in_vec_t clean;
    exe_in_vec_t rise;
    exe_in_vec_t fall;
    logic        stable;

    int checks = 0;
    int errors = 0;

    exe_05_input_conditioner dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_raw_in     (raw),
        .o_clean_out  (clean),
        .o_rise_pulse (rise),
        .o_fall_pulse (fall),
        .o_stable     (stable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then sample away from it
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input exe_in_vec_t r);
        rst = 1'b1;
        raw = r;
        tick(2);
        rst = 1'b0;
    endtask

    exe_in_vec_t seen_pulse;

    initial begin
        rst = 1'b1;
        raw = 3'b111;
        tick(3);
        // reset state while inputs are high
        chk("rst_clean",  clean,  0);
        chk("rst_rise",   rise,   0);
        chk("rst_fall",   fall,   0);
        chk("rst_stable", stable, 1);

        // release with inputs held high: accept on edge 6
        rst = 1'b0;
        tick(2);
        chk("rel_stable_e2", stable, 0);
        tick(3);
        chk("rel_clean_e5", clean, 0);
        tick(1);
        chk("rel_clean_e6", clean, 3'b111);
        chk("rel_rise_e6",  rise,  3'b111);
        tick(1);
        chk("rel_rise_e7",  rise,  0);

        // clean step on channel 0
        do_reset(3'b000);
        raw = 3'b001;
        tick(1);
        chk("step_stable_e1", stable, 1);
        tick(1);
        chk("step_stable_e2", stable, 0);
        tick(3);
        chk("step_stable_e5", stable, 0);
        chk("step_clean_e5",  clean,  0);
        chk("step_rise_e5",   rise,   0);
        tick(1);
        chk("step_clean_e6",  clean,  3'b001);
        chk("step_rise_e6",   rise,   3'b001);
        chk("step_stable_e6", stable, 1);
        tick(1);
        chk("step_rise_e7",   rise,   0);

        // glitch on channel 1: three samples high is one short of the threshold
        seen_pulse = '0;
        raw = 3'b011;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            seen_pulse |= rise | fall;
        end
        raw = 3'b001;
        for (int k = 0; k < 7; k++) begin
            tick(1);
            seen_pulse |= rise | fall;
        end
        chk("glitch_clean",  clean,      3'b001);
        chk("glitch_pulse",  seen_pulse, 0);
        chk("glitch_stable", stable,     1);

        // simultaneous change on all channels
        raw = 3'b110;
        tick(5);
        chk("sim_clean_e5", clean, 3'b001);
        tick(1);
        chk("sim_clean_e6", clean, 3'b110);
        chk("sim_rise_e6",  rise,  3'b110);
        chk("sim_fall_e6",  fall,  3'b001);
        tick(1);
        chk("sim_rise_e7",  rise,  0);
        chk("sim_fall_e7",  fall,  0);

        // reset on edge 4 discards the pending rise on channel 2
        do_reset(3'b000);
        tick(1);
        raw = 3'b100;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("midrst_clean", clean, 0);
        rst = 1'b0;
        seen_pulse = '0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            seen_pulse |= rise | fall;
        end
        chk("midrst_pulse_e5", seen_pulse, 0);
        chk("midrst_clean_e5", clean,      0);
        tick(1);
        chk("midrst_clean_e6", clean, 3'b100);
        chk("midrst_rise_e6",  rise,  3'b100);

        // channel 0 must hold steady while channel 2 changes
        do_reset(3'b000);
        raw = 3'b001;
        tick(7);
        chk("ds_clean_a", clean, 3'b001);
        raw = 3'b101;
        seen_pulse = '0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            seen_pulse[0] |= ~clean[0] | rise[0] | fall[0];
        end
        chk("ds_ch0_steady", seen_pulse, 0);
        chk("ds_clean_b",    clean,      3'b101);
        chk("ds_rise_b",     rise,       3'b100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
